// File: rtl/nms_frame_ctrl_if.sv
// Bus bundle for the NMS frame sequencer: the upstream pixel stream, the NMS
// advance/pixel path, the NMS result path, and the keypoint/status outputs.
// Member names are written from the sequencer's point of view.
interface nms_frame_ctrl_if #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int CW = 10
);
    logic          i_start;
    logic          i_valid;
    logic [7:0]    i_score;
    logic          i_flag;
    logic          o_ready;
    logic          o_nms_en;
    logic [7:0]    o_nms_score;
    logic          o_nms_flag;
    logic [7:0]    i_nms_score;
    logic          i_nms_flag;
    logic          o_kp_valid;
    logic [XW-1:0] o_kp_x;
    logic [YW-1:0] o_kp_y;
    logic [7:0]    o_kp_score;
    logic [CW-1:0] o_kp_count;
    logic          o_kp_overflow;
    logic          o_busy;
    logic          o_done;

    // Sequencer side
    modport slave (
        input  i_start, i_valid, i_score, i_flag, i_nms_score, i_nms_flag,
        output o_ready, o_nms_en, o_nms_score, o_nms_flag,
               o_kp_valid, o_kp_x, o_kp_y, o_kp_score, o_kp_count,
               o_kp_overflow, o_busy, o_done
    );

    // Environment side: upstream source, NMS instance, keypoint consumer
    modport master (
        output i_start, i_valid, i_score, i_flag, i_nms_score, i_nms_flag,
        input  o_ready, o_nms_en, o_nms_score, o_nms_flag,
               o_kp_valid, o_kp_x, o_kp_y, o_kp_score, o_kp_count,
               o_kp_overflow, o_busy, o_done
    );
endinterface

// File: rtl/nms_frame_ctrl.sv
// Frame sequencer around the non-maximum-suppression stage. Streams raster
// pixels into NMS, pads NMS_LAT extra cycles after the last pixel to drain
// the line buffer, and turns surviving NMS results into (x, y, score)
// keypoint events with border masking and a saturating per-frame count.
module nms_frame_ctrl #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int NMS_LAT = WIDTH + 4,
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int CW      = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    nms_frame_ctrl_if.slave  bus
);

    // Enabled cycles per frame: every pixel plus the drain padding.
    localparam int TOTAL = WIDTH * HEIGHT + NMS_LAT;
    localparam int KW    = $clog2(TOTAL + 1);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(1);
    localparam logic [YW-1:0] Y_MIN  = YW'(1);
    localparam logic [XW-1:0] X_MAX  = XW'(WIDTH - 2);
    localparam logic [YW-1:0] Y_MAX  = YW'(HEIGHT - 2);
    localparam logic [KW-1:0] K_LAT  = KW'(NMS_LAT);
    localparam logic [KW-1:0] K_LAST = KW'(TOTAL - 1);
    localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_start_acc;
    logic          w_ready;
    logic          w_en;
    logic [7:0]    w_nms_score;
    logic          w_nms_flag;
    logic          w_sample;
    logic          w_kp;

    logic [XW-1:0] r_in_x;
    logic [YW-1:0] r_in_y;
    logic [XW-1:0] r_out_x;
    logic [YW-1:0] r_out_y;
    logic [KW-1:0] r_k;

    logic          r_kp_vld_p1;
    logic [XW-1:0] r_kp_x_p1;
    logic [YW-1:0] r_kp_y_p1;
    logic [7:0]    r_kp_score_p1;
    logic [CW-1:0] r_kp_count;
    logic          r_kp_overflow;
    logic          r_busy;
    logic          r_done;

    // Count increment that sticks at the top value instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == C_MAX) ? c : c + CW'(1);
    endfunction

    // Next state, NMS enable and the pixel presented to NMS.
    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_ready     = 1'b0;
        w_en        = 1'b0;
        w_nms_score = 8'd0;
        w_nms_flag  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.i_start) begin
                    w_next      = S_STREAM;
                    w_start_acc = 1'b1;
                end
            end
            S_STREAM: begin
                w_ready     = 1'b1;
                w_en        = bus.i_valid;
                w_nms_score = bus.i_score;
                w_nms_flag  = bus.i_flag;
                if (bus.i_valid && r_in_x == X_LAST && r_in_y == Y_LAST)
                    w_next = S_FLUSH;
            end
            S_FLUSH: begin
                // Pad pixels (score 0, flag 0) push the tail of the frame out.
                w_en = 1'b1;
                if (r_k == K_LAST)
                    w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Results at the NMS output are valid once the pipeline has filled.
    assign w_sample = w_en && (r_k >= K_LAT);
    assign w_kp     = w_sample && bus.i_nms_flag &&
                      (r_out_x >= X_MIN) && (r_out_x <= X_MAX) &&
                      (r_out_y >= Y_MIN) && (r_out_y <= Y_MAX);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Input raster, output raster and enabled-cycle counters; all stall with NMS.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in_x  <= '0;
            r_in_y  <= '0;
            r_out_x <= '0;
            r_out_y <= '0;
            r_k     <= '0;
        end else if (w_start_acc) begin
            r_in_x  <= '0;
            r_in_y  <= '0;
            r_out_x <= '0;
            r_out_y <= '0;
            r_k     <= '0;
        end else begin
            if (w_en)
                r_k <= r_k + KW'(1);
            if (w_en && r_state == S_STREAM) begin
                if (r_in_x == X_LAST) begin
                    r_in_x <= '0;
                    r_in_y <= (r_in_y == Y_LAST) ? '0 : r_in_y + YW'(1);
                end else begin
                    r_in_x <= r_in_x + XW'(1);
                end
            end
            if (w_sample) begin
                if (r_out_x == X_LAST) begin
                    r_out_x <= '0;
                    r_out_y <= (r_out_y == Y_LAST) ? '0 : r_out_y + YW'(1);
                end else begin
                    r_out_x <= r_out_x + XW'(1);
                end
            end
        end
    end

    // Sample -> keypoint event stage; coordinates and score hold between pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_kp_vld_p1   <= 1'b0;
            r_kp_x_p1     <= '0;
            r_kp_y_p1     <= '0;
            r_kp_score_p1 <= '0;
        end else begin
            r_kp_vld_p1 <= w_kp;
            if (w_kp) begin
                r_kp_x_p1     <= r_out_x;
                r_kp_y_p1     <= r_out_y;
                r_kp_score_p1 <= bus.i_nms_score;
            end
        end
    end

    // Per-frame keypoint count with sticky overflow once saturated.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_kp_count    <= '0;
            r_kp_overflow <= 1'b0;
        end else if (w_start_acc) begin
            r_kp_count    <= '0;
            r_kp_overflow <= 1'b0;
        end else if (w_kp) begin
            r_kp_count    <= sat_inc(r_kp_count);
            r_kp_overflow <= r_kp_overflow | (r_kp_count == C_MAX);
        end
    end

    // Registered status: busy tracks the state, done pulses on entry to DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_STREAM) || (w_next == S_FLUSH);
            r_done <= (r_state == S_FLUSH) && (w_next == S_DONE);
        end
    end

    assign bus.o_ready       = w_ready;
    assign bus.o_nms_en      = w_en;
    assign bus.o_nms_score   = w_nms_score;
    assign bus.o_nms_flag    = w_nms_flag;
    assign bus.o_kp_valid    = r_kp_vld_p1;
    assign bus.o_kp_x        = r_kp_x_p1;
    assign bus.o_kp_y        = r_kp_y_p1;
    assign bus.o_kp_score    = r_kp_score_p1;
    assign bus.o_kp_count    = r_kp_count;
    assign bus.o_kp_overflow = r_kp_overflow;
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;

endmodule
